// File: rtl/mac_lookup_arbiter_pkg.sv
// Shared Ethernet bus types and the card-local to global port translation used by the lookup arbiter.
package mac_lookup_arbiter_pkg;

    typedef logic [11:0] vlan_t;
    typedef logic [47:0] macaddr_t;

    // Callers truncate to their global port width, so the sum wraps modulo 2^width.
    function automatic logic [31:0] global_port(input logic [31:0] card,
                                                input logic [31:0] local_port,
                                                input logic [31:0] ports_per_card);
        return card * ports_per_card + local_port;
    endfunction

endpackage

// File: rtl/lookup_tag_fifo.sv
// In-order register FIFO of requester tags; accepts push on a full FIFO when a pop happens the same cycle.
module lookup_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_mem[gi] <= '0;
                end else if (w_push_ok && (r_wr_ptr == PTR_W'(gi))) begin
                    r_mem[gi] <= i_push_data;
                end
            end
        end
    endgenerate

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mac_lookup_arbiter.sv
// Round-robin sharing of one MAC table lookup port among line cards, with in-order result routing
// back to the requesting card and card-local to global source port translation.
module mac_lookup_arbiter
    import mac_lookup_arbiter_pkg::*;
#(
    parameter int NUM_CARDS        = 2,
    parameter int PORTS_PER_CARD   = 24,
    parameter int LOCAL_PORT_BITS  = 5,
    parameter int GLOBAL_PORT_BITS = 6,
    parameter int MAX_OUTSTANDING  = 4
)(
    input  logic                                       clk_fabric,
    input  logic                                       rst_n,
    input  logic [NUM_CARDS-1:0]                       req_valid,
    output logic [NUM_CARDS-1:0]                       req_ready,
    input  vlan_t [NUM_CARDS-1:0]                      req_vlan,
    input  macaddr_t [NUM_CARDS-1:0]                   req_src_mac,
    input  logic [NUM_CARDS-1:0][LOCAL_PORT_BITS-1:0]  req_src_port,
    input  macaddr_t [NUM_CARDS-1:0]                   req_dst_mac,
    output logic [NUM_CARDS-1:0]                       rsp_valid,
    output logic                                       rsp_hit,
    output logic [GLOBAL_PORT_BITS-1:0]                rsp_dst_port,
    output logic                                       tbl_lookup_en,
    output vlan_t                                      tbl_src_vlan,
    output macaddr_t                                   tbl_src_mac,
    output macaddr_t                                   tbl_dst_mac,
    output logic [GLOBAL_PORT_BITS-1:0]                tbl_src_port,
    input  logic                                       tbl_done,
    input  logic                                       tbl_hit,
    input  logic [GLOBAL_PORT_BITS-1:0]                tbl_dst_port,
    output logic                                       err_underflow
);

    localparam int TAG_W = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [TAG_W-1:0]            r_rr_ptr;
    logic                        r_tbl_lookup_en;
    vlan_t                       r_tbl_src_vlan;
    macaddr_t                    r_tbl_src_mac;
    macaddr_t                    r_tbl_dst_mac;
    logic [GLOBAL_PORT_BITS-1:0] r_tbl_src_port;
    logic [NUM_CARDS-1:0]        r_rsp_valid;
    logic                        r_rsp_hit;
    logic [GLOBAL_PORT_BITS-1:0] r_rsp_dst_port;
    logic                        r_err_underflow;

    logic [NUM_CARDS-1:0]        w_grant;
    logic [TAG_W-1:0]            w_grant_idx;
    logic                        w_found;
    logic [TAG_W:0]              w_scan_idx;
    logic                        w_hs;
    logic                        w_pop;
    logic                        w_underflow;
    logic [TAG_W-1:0]            w_fifo_head;
    logic [CNT_W-1:0]            w_fifo_count;
    logic                        w_fifo_empty;
    logic                        w_fifo_full;
    logic [NUM_CARDS-1:0]        w_head_onehot;
    logic [GLOBAL_PORT_BITS-1:0] w_gport [NUM_CARDS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CARDS; gi++) begin : g_card
            assign w_gport[gi] = GLOBAL_PORT_BITS'(global_port(32'(gi), 32'(req_src_port[gi]),
                                                               32'(PORTS_PER_CARD)));
            assign w_head_onehot[gi] = (w_fifo_head == TAG_W'(gi));
        end
    endgenerate

    // Full is taken from the registered count only, so tbl_done never reaches req_ready.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_scan_idx  = '0;
        if (!w_fifo_full) begin
            for (int k = 0; k < NUM_CARDS; k++) begin
                w_scan_idx = (TAG_W+1)'(r_rr_ptr) + (TAG_W+1)'(k);
                if (w_scan_idx >= (TAG_W+1)'(NUM_CARDS)) begin
                    w_scan_idx = w_scan_idx - (TAG_W+1)'(NUM_CARDS);
                end
                if (!w_found && req_valid[w_scan_idx[TAG_W-1:0]]) begin
                    w_found                          = 1'b1;
                    w_grant_idx                      = w_scan_idx[TAG_W-1:0];
                    w_grant[w_scan_idx[TAG_W-1:0]]   = 1'b1;
                end
            end
        end
    end

    assign req_ready   = w_grant & {NUM_CARDS{rst_n}};
    assign w_hs        = w_found & rst_n;
    assign w_pop       = tbl_done & ~w_fifo_empty;
    assign w_underflow = tbl_done & (w_fifo_count == '0);

    lookup_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .i_clk       (clk_fabric),
        .i_rst_n     (rst_n),
        .i_push      (w_hs),
        .i_push_data (w_grant_idx),
        .i_pop       (tbl_done),
        .o_head      (w_fifo_head),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    always_ff @(posedge clk_fabric or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr        <= '0;
            r_tbl_lookup_en <= 1'b0;
            r_tbl_src_vlan  <= '0;
            r_tbl_src_mac   <= '0;
            r_tbl_dst_mac   <= '0;
            r_tbl_src_port  <= '0;
        end else begin
            r_tbl_lookup_en <= w_hs;
            if (w_hs) begin
                r_rr_ptr       <= (w_grant_idx == TAG_W'(NUM_CARDS - 1)) ? '0
                                                                          : w_grant_idx + TAG_W'(1);
                r_tbl_src_vlan <= req_vlan[w_grant_idx];
                r_tbl_src_mac  <= req_src_mac[w_grant_idx];
                r_tbl_dst_mac  <= req_dst_mac[w_grant_idx];
                r_tbl_src_port <= w_gport[w_grant_idx];
            end
        end
    end

    // Result fields only move on a real pop so they hold between strobes.
    always_ff @(posedge clk_fabric or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid     <= '0;
            r_rsp_hit       <= 1'b0;
            r_rsp_dst_port  <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            r_rsp_valid <= w_pop ? w_head_onehot : '0;
            if (w_pop) begin
                r_rsp_hit      <= tbl_hit;
                r_rsp_dst_port <= tbl_dst_port;
            end
            if (w_underflow) r_err_underflow <= 1'b1;
        end
    end

    assign tbl_lookup_en = r_tbl_lookup_en;
    assign tbl_src_vlan  = r_tbl_src_vlan;
    assign tbl_src_mac   = r_tbl_src_mac;
    assign tbl_dst_mac   = r_tbl_dst_mac;
    assign tbl_src_port  = r_tbl_src_port;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_hit       = r_rsp_hit;
    assign rsp_dst_port  = r_rsp_dst_port;
    assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_mac_lookup_arbiter.sv
// Randomized bench for mac_lookup_arbiter: behavioural requesters, an in-order table model and a
// queue-based reference of grants, issued lookups and routed responses.
module tb_mac_lookup_arbiter;
    import mac_lookup_arbiter_pkg::*;

    localparam int NC   = 2;
    localparam int PPC  = 24;
    localparam int LPB  = 5;
    localparam int GPB  = 6;
    localparam int MAXO = 4;

    logic                      clk_fabric = 1'b0;
    logic                      rst_n;
    logic [NC-1:0]             req_valid;
    logic [NC-1:0]             req_ready;
    vlan_t [NC-1:0]            req_vlan;
    macaddr_t [NC-1:0]         req_src_mac;
    logic [NC-1:0][LPB-1:0]    req_src_port;
    macaddr_t [NC-1:0]         req_dst_mac;
    logic [NC-1:0]             rsp_valid;
    logic                      rsp_hit;
    logic [GPB-1:0]            rsp_dst_port;
    logic                      tbl_lookup_en;
    vlan_t                     tbl_src_vlan;
    macaddr_t                  tbl_src_mac;
    macaddr_t                  tbl_dst_mac;
    logic [GPB-1:0]            tbl_src_port;
    logic                      tbl_done;
    logic                      tbl_hit;
    logic [GPB-1:0]            tbl_dst_port;
    logic                      err_underflow;

    mac_lookup_arbiter #(
        .NUM_CARDS(NC), .PORTS_PER_CARD(PPC), .LOCAL_PORT_BITS(LPB),
        .GLOBAL_PORT_BITS(GPB), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_fabric(clk_fabric), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_vlan(req_vlan),
        .req_src_mac(req_src_mac), .req_src_port(req_src_port), .req_dst_mac(req_dst_mac),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_dst_port(rsp_dst_port),
        .tbl_lookup_en(tbl_lookup_en), .tbl_src_vlan(tbl_src_vlan), .tbl_src_mac(tbl_src_mac),
        .tbl_dst_mac(tbl_dst_mac), .tbl_src_port(tbl_src_port),
        .tbl_done(tbl_done), .tbl_hit(tbl_hit), .tbl_dst_port(tbl_dst_port),
        .err_underflow(err_underflow)
    );

    always #5 clk_fabric = ~clk_fabric;

    typedef struct {
        int             due;
        bit             hit;
        logic [GPB-1:0] port;
    } tbl_ent_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model
    int       tagq[$];
    int       m_ptr;
    bit       m_err;
    bit       m_iss_pend;
    vlan_t    m_iss_vlan;
    macaddr_t m_iss_smac;
    macaddr_t m_iss_dmac;
    int       m_iss_port;
    bit       m_rsp_pend;
    int       m_rsp_card;
    bit       m_last_hit;
    int       m_last_port;

    // table model and stimulus knobs
    tbl_ent_t      tq[$];
    int            last_due;
    int            lat_min = 0;
    int            lat_max = 6;
    int            done_budget = -1;
    bit            spurious;
    int            p_req = 0;
    int            inj_q[$];
    bit            inj_fixed;
    bit            pending_release;
    logic [NC-1:0] hs_mask;
    int            grants[NC];
    int            grants_total;
    int            hs_cyc;
    int            last_rsp_cyc;
    int            last_iss_port;
    logic [NC-1:0] rsp_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        tagq.delete();
        tq.delete();
        m_ptr = 0; m_err = 0; m_iss_pend = 0; m_rsp_pend = 0;
        m_last_hit = 0; m_last_port = 0;
        hs_mask = '0; last_due = 0; spurious = 0; done_budget = -1;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_hit", rsp_hit, 0);
        check("rst_rsp_dst_port", rsp_dst_port, 0);
        check("rst_lookup_en", tbl_lookup_en, 0);
        check("rst_src_vlan", tbl_src_vlan, 0);
        check("rst_src_mac", tbl_src_mac, 0);
        check("rst_dst_mac", tbl_dst_mac, 0);
        check("rst_src_port", tbl_src_port, 0);
        check("rst_err", err_underflow, 0);
    endtask

    task automatic new_req(input int c, input bit fixed);
        req_valid[c]    = 1'b1;
        req_vlan[c]     = fixed ? vlan_t'(10) : vlan_t'($urandom);
        req_src_port[c] = fixed ? LPB'(3) : LPB'($urandom);
        req_src_mac[c]  = macaddr_t'({$urandom, $urandom});
        req_dst_mac[c]  = macaddr_t'({$urandom, $urandom});
    endtask

    task automatic step();
        tbl_ent_t      e;
        int            g;
        logic [NC-1:0] exp_ready;
        @(negedge clk_fabric);
        cyc++;
        if (pending_release) begin
            rst_n = 1'b1;
            pending_release = 0;
        end
        // table side: accept the lookup visible this cycle, then answer in order
        if (tbl_lookup_en) begin
            e.due  = cyc + int'($urandom_range(lat_max, lat_min));
            if (e.due <= last_due) e.due = last_due + 1;
            e.hit  = 1'($urandom);
            e.port = GPB'($urandom);
            tq.push_back(e);
            last_due = e.due;
            last_iss_port = int'(tbl_src_port);
        end
        req_valid = req_valid & ~hs_mask;
        for (int c = 0; c < NC; c++) begin
            if (!req_valid[c] && ($urandom_range(99) < p_req)) new_req(c, 0);
        end
        if (inj_q.size() > 0 && !req_valid[inj_q[0]]) new_req(inj_q.pop_front(), inj_fixed);
        tbl_done     = 1'b0;
        tbl_hit      = 1'($urandom);
        tbl_dst_port = GPB'($urandom);
        if (done_budget != 0 && tq.size() > 0 && tq[0].due <= cyc) begin
            tbl_done     = 1'b1;
            tbl_hit      = tq[0].hit;
            tbl_dst_port = tq[0].port;
            void'(tq.pop_front());
            if (done_budget > 0) done_budget--;
        end else if (spurious) begin
            tbl_done = 1'b1;
            spurious = 0;
        end
        #1;
        // expected grant: first valid card at or after the pointer, only while below capacity
        g = -1;
        if (tagq.size() < MAXO) begin
            for (int k = 0; k < NC; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NC]) g = (m_ptr + k) % NC;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        check("lookup_en", tbl_lookup_en, m_iss_pend);
        if (m_iss_pend) begin
            check("src_vlan", tbl_src_vlan, m_iss_vlan);
            check("src_mac", tbl_src_mac, m_iss_smac);
            check("dst_mac", tbl_dst_mac, m_iss_dmac);
            check("src_port", tbl_src_port, m_iss_port);
        end
        exp_ready = '0;
        if (m_rsp_pend) exp_ready[m_rsp_card] = 1'b1;
        check("rsp_valid", rsp_valid, exp_ready);
        check("rsp_hit", rsp_hit, m_last_hit);
        check("rsp_dst_port", rsp_dst_port, m_last_port);
        check("err_underflow", err_underflow, m_err);
        if (rsp_valid != '0) begin
            $display("rsp cycle=%0d card_mask=%b hit=%0d port=%0d", cyc, rsp_valid, rsp_hit, rsp_dst_port);
            last_rsp_cyc = cyc;
            rsp_log.push_back(rsp_valid);
        end
        hs_mask = req_valid & req_ready;
        for (int c = 0; c < NC; c++) begin
            if (hs_mask[c]) begin
                grants[c]++;
                grants_total++;
                hs_cyc = cyc;
            end
        end
        // advance the model across the coming edge; pop sees the queue before this cycle's push
        m_rsp_pend = 0;
        if (tbl_done) begin
            if (tagq.size() == 0) m_err = 1;
            else begin
                m_rsp_card  = tagq.pop_front();
                m_rsp_pend  = 1;
                m_last_hit  = tbl_hit;
                m_last_port = int'(tbl_dst_port);
            end
        end
        m_iss_pend = (g >= 0);
        if (g >= 0) begin
            m_iss_vlan = req_vlan[g];
            m_iss_smac = req_src_mac[g];
            m_iss_dmac = req_dst_mac[g];
            m_iss_port = (g * PPC + int'(req_src_port[g])) % (1 << GPB);
            tagq.push_back(g);
            m_ptr = (g + 1) % NC;
        end
    endtask

    task automatic drain();
        int n;
        p_req = 0;
        done_budget = -1;
        n = 0;
        while ((tagq.size() > 0 || tq.size() > 0 || req_valid != '0) && n < 300) begin
            step();
            n++;
        end
        check("drain_timeout", (n < 300), 1);
        repeat (2) step();
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        tbl_done  = 1'b0;
        req_valid = '1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk_fabric);
        pending_release = 1;
        p_req = 100;
        step();
        check("first_grant_card0", hs_mask, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_vlan = '0; req_src_mac = '0; req_src_port = '0; req_dst_mac = '0;
        tbl_done = 1'b0; tbl_hit = 1'b0; tbl_dst_port = '0;
        pending_release = 0; inj_fixed = 0; grants_total = 0; hs_cyc = 0; last_rsp_cyc = 0;
        for (int c = 0; c < NC; c++) grants[c] = 0;
        repeat (3) @(posedge clk_fabric);
        @(negedge clk_fabric);
        apply_reset();

        // random traffic with random table latency
        p_req = 60; lat_min = 0; lat_max = 6;
        repeat (1500) step();
        drain();

        // single card-1 request, table latency 4
        lat_min = 4; lat_max = 4;
        inj_fixed = 1; inj_q.push_back(1);
        hs_cyc = -100; last_rsp_cyc = -1;
        repeat (12) step();
        inj_fixed = 0;
        check("single_src_port", last_iss_port, 27);
        check("single_latency", last_rsp_cyc - hs_cyc, 6);
        drain();

        // both cards continuously valid, zero-latency table
        lat_min = 0; lat_max = 0;
        for (int c = 0; c < NC; c++) grants[c] = 0;
        p_req = 100;
        repeat (40) step();
        check("fair_card0", grants[0], 20);
        check("fair_card1", grants[1], 20);
        drain();

        // interleaved requesters 0,1,1,0
        lat_min = 0; lat_max = 3;
        rsp_log.delete();
        inj_q = '{0, 1, 1, 0};
        repeat (30) step();
        check("interleave_count", rsp_log.size(), 4);
        if (rsp_log.size() == 4) begin
            check("interleave_rsp0", rsp_log[0], 2'b01);
            check("interleave_rsp1", rsp_log[1], 2'b10);
            check("interleave_rsp2", rsp_log[2], 2'b10);
            check("interleave_rsp3", rsp_log[3], 2'b01);
        end
        drain();

        // stalled table: capacity limit, then one answer frees one slot
        lat_min = 1; lat_max = 3;
        grants_total = 0;
        done_budget = 0; p_req = 100;
        repeat (10) step();
        check("stall_grants", grants_total, MAXO);
        done_budget = 1;
        repeat (3) step();
        check("stall_one_more", grants_total, MAXO + 1);
        drain();

        // spurious table answer
        spurious = 1;
        repeat (6) step();
        check("underflow_sticky", err_underflow, 1);

        // reset with three lookups in flight
        done_budget = 0; p_req = 0;
        inj_q = '{0, 1, 0};
        repeat (6) step();
        check("inflight_before_reset", tagq.size(), 3);
        apply_reset();
        p_req = 50; lat_min = 0; lat_max = 5;
        repeat (300) step();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
